// File: rtl/apb_cfg_pkg.sv
// apb_cfg_pkg: FSM state type, register-map offsets of the image-filter
// register slave and the default ACCESS timeout for apb_cfg_master.
package apb_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  localparam int unsigned ADDR_WIDTH_DEF     = 10;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  localparam logic [9:0] CSC_COEF0     = 10'h000;
  localparam logic [9:0] CSC_COEF1     = 10'h004;
  localparam logic [9:0] CSC_COEF2     = 10'h008;
  localparam logic [9:0] CSC_BIAS      = 10'h00A;
  localparam logic [9:0] ICSC_COEF0    = 10'h010;
  localparam logic [9:0] ICSC_COEF1    = 10'h014;
  localparam logic [9:0] ICSC_COEF2    = 10'h018;
  localparam logic [9:0] ICSC_BIAS     = 10'h01A;
  localparam logic [9:0] FILTER1_FIRST = 10'h020;
  localparam logic [9:0] FILTER1_LAST  = 10'h044;
  localparam logic [9:0] FILTER2_FIRST = 10'h048;
  localparam logic [9:0] FILTER2_LAST  = 10'h06A;
  localparam logic [9:0] BYPASS        = 10'h070;

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles without PREADY and flags the
// cycle that would reach LIMIT. Ports: clk, rst, i_clear, i_inc, o_limit.
module apb_timeout_cnt
  import apb_cfg_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_limit
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Asserted during the LIMIT-th waiting ACCESS cycle, so the FSM
  // leaves ACCESS after exactly LIMIT cycles.
  assign o_limit = i_inc & (r_cnt == LP_LAST);

endmodule

// File: rtl/apb_cfg_master.sv
// apb_cfg_master: single-outstanding APB requester; cmd valid/ready in,
// APB SETUP/ACCESS out, rsp valid/ready back. Macro: APB_TIMEOUT_EN.
// Ports: clk, rst, i_cmd_*, o_cmd_ready, o_rsp_*, i_rsp_ready, APB bus.
module apb_cfg_master
  import apb_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [31:0]           o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [31:0]           i_PRDATA
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e            r_state, w_state_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [31:0]           r_pwdata, w_pwdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]           r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  w_timeout;

`ifdef APB_TIMEOUT_EN
  logic w_cnt_clear;
  logic w_cnt_inc;

  assign w_cnt_clear = (r_state == ST_SETUP);
  assign w_cnt_inc   = (r_state == ST_ACCESS) & ~i_PREADY;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clear),
    .i_inc   (w_cnt_inc),
    .o_limit (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // APB strobes are registered copies of the next state's decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    unique case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_state_nxt  = ST_SETUP;
          w_psel_nxt   = 1'b1;
          w_pwrite_nxt = i_cmd_write;
          w_paddr_nxt  = i_cmd_addr;
          w_pwdata_nxt = i_cmd_wdata;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        // PREADY takes priority over a same-cycle timeout.
        if (i_PREADY) begin
          w_state_nxt     = ST_RESP;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_pwrite ? 32'h0 : i_PRDATA;
          w_rsp_err_nxt   = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt     = ST_RESP;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = 32'h0;
          w_rsp_err_nxt   = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_PSEL      = r_psel;
  assign o_PENABLE   = r_penable;
  assign o_PWRITE    = r_pwrite;
  assign o_PADDR     = r_paddr;
  assign o_PWDATA    = r_pwdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: directed bench for apb_cfg_master with a small APB
// completer model and a response scoreboard.
module tb_apb_cfg_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [9:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [9:0]  o_PADDR;
  logic        o_PSEL;
  logic        o_PENABLE;
  logic        o_PWRITE;
  logic [31:0] o_PWDATA;
  logic        i_PREADY;
  logic [31:0] i_PRDATA;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_cfg_master dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_write (i_cmd_write),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_wdata (i_cmd_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_PADDR     (o_PADDR),
    .o_PSEL      (o_PSEL),
    .o_PENABLE   (o_PENABLE),
    .o_PWRITE    (o_PWRITE),
    .o_PWDATA    (o_PWDATA),
    .i_PREADY    (i_PREADY),
    .i_PRDATA    (i_PRDATA)
  );

  // Completer: PREADY after `waits` wait states; force_rdy holds it high.
  int          waits = 0;
  bit          force_rdy = 1'b0;
  int          wcnt = 0;
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] wmask(input logic [9:0] a,
                                        input logic [31:0] d);
    if (a == 10'h000) return d & 32'h3FFF_FFFF;
    if (a == 10'h070) return d & 32'h0000_000F;
    return d;
  endfunction

  always @(posedge clk) begin
    if (o_PSEL && o_PENABLE && !i_PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (o_PSEL && o_PENABLE && i_PREADY && o_PWRITE)
      mem[o_PADDR] <= wmask(o_PADDR, o_PWDATA);
  end

  always_comb begin
    i_PREADY = force_rdy | (o_PSEL & o_PENABLE & (wcnt == waits));
    i_PRDATA = mem[o_PADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input bit wr, input logic [9:0] a,
                        input logic [31:0] d, input int w, input bit frc,
                        input int exp_n, input logic [31:0] exp_rd,
                        input bit exp_err, input int hold);
    rsp_t e;
    int   n;
    waits     = w;
    force_rdy = frc;
    chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_wdata = d;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_addr  = ~a;
    i_cmd_wdata = ~d;
    chk("setup_psel", 32'(o_PSEL), 32'd1);
    chk("setup_penable", 32'(o_PENABLE), 32'd0);
    chk("setup_paddr", 32'(o_PADDR), 32'(a));
    chk("setup_pwrite", 32'(o_PWRITE), 32'(wr));
    chk("setup_pwdata", o_PWDATA, d);
    chk("setup_cmd_ready", 32'(o_cmd_ready), 32'd0);
    n = 0;
    @(negedge clk);
    while (o_PSEL === 1'b1 && n < 100) begin
      chk("acc_penable", 32'(o_PENABLE), 32'd1);
      chk("acc_paddr", 32'(o_PADDR), 32'(a));
      chk("acc_pwdata", o_PWDATA, d);
      chk("acc_cmd_ready", 32'(o_cmd_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("access_len", 32'(n), 32'(exp_n));
    chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("rsp_penable", 32'(o_PENABLE), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("rsp_rdata", o_rsp_rdata, e.rdata);
    chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
    force_rdy   = 1'b0;
    i_cmd_valid = (hold > 0);
    i_cmd_write = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_rdata", o_rsp_rdata, e.rdata);
      chk("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
      chk("bp_psel", 32'(o_PSEL), 32'd0);
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk("hs_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("hs_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("hs_psel", 32'(o_PSEL), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_psel", 32'(o_PSEL), 32'd0);
    chk("rst_penable", 32'(o_PENABLE), 32'd0);
    chk("rst_pwrite", 32'(o_PWRITE), 32'd0);
    chk("rst_paddr", 32'(o_PADDR), 32'd0);
    chk("rst_pwdata", o_PWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_wdata = '0;
    i_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    do_cmd(1'b1, 10'h070, 32'h0000_0005, 1, 1'b0, 2, 32'h0, 1'b0, 0);
    chk("bypass_bits", mem[10'h070], 32'h0000_0005);
    do_cmd(1'b0, 10'h070, 32'h0, 1, 1'b0, 2, 32'h0000_0005, 1'b0, 0);
    do_cmd(1'b1, 10'h000, 32'h1234_5678, 1, 1'b0, 2, 32'h0, 1'b0, 0);
    do_cmd(1'b0, 10'h000, 32'h0, 1, 1'b0, 2, 32'h1234_5678, 1'b0, 6);
    do_cmd(1'b1, 10'h000, 32'hFFFF_FFFF, 1, 1'b0, 2, 32'h0, 1'b0, 0);
    do_cmd(1'b0, 10'h000, 32'h0, 0, 1'b1, 1, 32'h3FFF_FFFF, 1'b0, 0);
    do_cmd(1'b1, 10'h044, 32'hA5A5_5A5A, 3, 1'b0, 4, 32'h0, 1'b0, 2);
    do_cmd(1'b0, 10'h044, 32'h0, 3, 1'b0, 4, 32'hA5A5_5A5A, 1'b0, 0);
`ifdef APB_TIMEOUT_EN
    do_cmd(1'b0, 10'h044, 32'h0, 1000, 1'b0, 16, 32'h0, 1'b1, 0);
`endif

    waits       = 5;
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = 10'h008;
    i_cmd_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_access", 32'(o_PENABLE), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
    end
    chk("post_rst_no_write", mem[10'h008], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
